// File: rtl/reset_sequencer.sv
// reset_sequencer: holds all stages in reset, then releases them in order as each prior stage reports ready
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   soft_reset_req    - one-cycle request to restart the whole sequence (also clears the error)
//   stage_ready       - per-stage ready, bit i from stage i
//   stage_reset       - per-stage reset, bit i high holds stage i in reset
//   all_ready, busy   - sequence complete / sequence in progress
//   timeout_err       - sticky timeout flag, failed_stage names the stage that timed out
module reset_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  soft_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  all_ready,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [IDX_W-1:0]      failed_stage
);
  localparam int CMAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [NUM_STAGES-1:0] ONES = '1;
  typedef enum logic [1:0] {S_HOLD, S_WAIT, S_DONE, S_ERROR} state_e;
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, fail_q, fail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [NUM_STAGES-1:0] sr_q, sr_d, low_mask;
  logic all_ready_q, busy_q;
  // stages below idx are already released and must stay ready
  assign low_mask = ~(ONES << idx_q);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = (cnt_q == CW'(CMAX)) ? cnt_q : cnt_q + 1'b1;
    err_d = err_q;
    fail_d = fail_q;
    if (soft_reset_req) begin
      state_d = S_HOLD;
      idx_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
      fail_d = '0;
    end else begin
      case (state_q)
        S_HOLD: if (cnt_q >= CW'(HOLD_CYCLES - 1)) begin
          state_d = S_WAIT;
          idx_d = '0;
          cnt_d = '0;
        end
        S_WAIT: if ((stage_ready & low_mask) != low_mask) begin
          state_d = S_HOLD;
          idx_d = '0;
          cnt_d = '0;
        end else if (stage_ready[idx_q]) begin
          state_d = (idx_q == IDX_W'(NUM_STAGES - 1)) ? S_DONE : S_WAIT;
          idx_d = (idx_q == IDX_W'(NUM_STAGES - 1)) ? idx_q : idx_q + 1'b1;
          cnt_d = '0;
        end else if (cnt_q >= CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERROR;
          err_d = 1'b1;
          fail_d = idx_q;
        end
        S_DONE: if (stage_ready != ONES) begin
          state_d = S_HOLD;
          idx_d = '0;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    // in WAIT, stages 0..idx are released, so the reset vector is ones shifted past idx
    sr_d = (state_d == S_WAIT) ? ONES << (32'(idx_d) + 1) : (state_d == S_DONE) ? '0 : ONES;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HOLD;
      idx_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      fail_q <= '0;
      sr_q <= ONES;
      all_ready_q <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      fail_q <= fail_d;
      sr_q <= sr_d;
      all_ready_q <= state_d == S_DONE;
      busy_q <= (state_d == S_HOLD) || (state_d == S_WAIT);
    end
  end
  assign stage_reset = sr_q;
  assign all_ready = all_ready_q;
  assign busy = busy_q;
  assign timeout_err = err_q;
  assign failed_stage = fail_q;
endmodule
